axis_rx_mailbox: RTL and testbench

// - AXI-Stream sink (64-bit, tkeep/tlast) that buffers received beats in a FIFO; the CPU drains it via an AXI4-Lite slave register map.
// - It is the responder to the testbench's AXI4-Lite master tasks and the stream sink for its stream_send beats.
// - Used as a PS-visible capture point for dataplane stream traffic.

---
 rtl/axis_rx_mailbox_pkg.sv | 40 ++++
 rtl/axis_rx_fifo.sv | 66 ++++++
 rtl/axis_rx_mailbox.sv | 230 +++++++++++++++++++++++
 tb/tb_axis_rx_mailbox.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/axis_rx_mailbox_pkg.sv
// Shared definitions for the AXI-Stream receive mailbox: register offsets,
// STATUS bit layout, AXI response codes, FIFO entry layout and FSM states.
package axis_rx_mailbox_pkg;

  localparam logic [31:0] REG_STATUS    = 32'h0000_0000;
  localparam logic [31:0] REG_DATA_LO   = 32'h0000_0004;
  localparam logic [31:0] REG_DATA_HI   = 32'h0000_0008;
  localparam logic [31:0] REG_CTRL      = 32'h0000_000C;
  localparam logic [31:0] REG_FRAME_CNT = 32'h0000_0010;
  localparam logic [31:0] REG_DROP_CNT  = 32'h0000_0014;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_TLAST     = 2;
  localparam int STAT_KEEP_LSB  = 8;
  localparam int STAT_LEVEL_LSB = 16;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic        tlast;
    logic [7:0]  tkeep;
    logic [63:0] tdata;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;

  function automatic logic reg_mapped(input logic [31:0] off);
    case (off)
      REG_STATUS, REG_DATA_LO, REG_DATA_HI,
      REG_CTRL, REG_FRAME_CNT, REG_DROP_CNT: reg_mapped = 1'b1;
      default:                               reg_mapped = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/axis_rx_fifo.sv
// Show-ahead synchronous FIFO with flush; push when full and pop when empty
// are ignored, and flush overrides both.
module axis_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 73,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level,
  output logic [AW:0]      level_next
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r, wr_ptr_n, rd_ptr_n;
  logic [AW:0]      level_r;
  logic             do_push_s, do_pop_s;

  // Next pointer and level values.
  always_comb begin
    do_push_s = push && !full && !flush;
    do_pop_s  = pop && !empty && !flush;
    if (flush) begin
      wr_ptr_n   = {AW{1'b0}};
      rd_ptr_n   = {AW{1'b0}};
      level_next = {(AW+1){1'b0}};
    end else begin
      wr_ptr_n   = do_push_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
      rd_ptr_n   = do_pop_s  ? rd_ptr_r + AW'(1) : rd_ptr_r;
      level_next = level_r + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_n;
      rd_ptr_r <= rd_ptr_n;
      level_r  <= level_next;
    end
  end

  // Storage array; contents are only observed through a non-empty head.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign level = level_r;
  assign full  = (level_r == (AW+1)'(DEPTH));
  assign empty = (level_r == {(AW+1){1'b0}});

endmodule

// File: rtl/axis_rx_mailbox.sv
// AXI-Stream capture mailbox drained through an AXI4-Lite register map.
// Define AXIS_RX_OVERFLOW_DROP_EN to drop (and count) beats on overflow instead of backpressuring.
module axis_rx_mailbox
  import axis_rx_mailbox_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] AWADDR,
  input  logic [2:0]  AWPROT,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  input  logic        WVALID,
  output logic        WREADY,
  output logic [1:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY,
  input  logic [31:0] ARADDR,
  input  logic [2:0]  ARPROT,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RVALID,
  input  logic        RREADY,
  input  logic [63:0] tdata,
  input  logic [7:0]  tkeep,
  input  logic        tlast,
  input  logic        tvalid,
  output logic        tready
);

  localparam int LW = $clog2(DEPTH) + 1;

  wr_state_t   wstate_r, wstate_n;
  rd_state_t   rstate_r, rstate_n;
  logic        awready_r, awready_n, bvalid_r, bvalid_n;
  logic [1:0]  bresp_r, bresp_n, rresp_r, rresp_n, rd_resp_s;
  logic        arready_r, arready_n, rvalid_r, rvalid_n;
  logic [31:0] rdata_r, rdata_n, rd_mux_s, aw_off_s, ar_off_s, status_s;
  logic        wr_en_s, rd_en_s, pop_s, flush_s, enable_r, enable_n, tready_r, tready_n;
  logic        full_s, empty_s, push_ok_s;
  logic [LW-1:0] level_s, level_next_s;
  entry_t      head_raw_s, head_s;
  logic [31:0] frame_cnt_r, drop_cnt_s;
  logic        unused_s;

  assign aw_off_s = 32'({AWADDR[ADDR_W-1:2], 2'b00});
  assign ar_off_s = 32'({ARADDR[ADDR_W-1:2], 2'b00});
  assign unused_s = ^{AWPROT, ARPROT, AWADDR[31:ADDR_W], AWADDR[1:0],
                      ARADDR[31:ADDR_W], ARADDR[1:0], WDATA[31:2], WSTRB[3:1]};

  axis_rx_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(tvalid && tready_r), .pop(pop_s), .flush(flush_s),
    .din({tlast, tkeep, tdata}), .head(head_raw_s),
    .full(full_s), .empty(empty_s), .level(level_s), .level_next(level_next_s)
  );

  // Stale storage is hidden so an empty FIFO always reads as zero.
  assign head_s    = empty_s ? {ENTRY_W{1'b0}} : head_raw_s;
  assign push_ok_s = tvalid && tready_r && !full_s && !flush_s;
  assign pop_s     = rd_en_s && (ar_off_s == REG_DATA_HI) && !empty_s;

  // Write channel FSM: registered AWREADY/WREADY pulse, then hold BVALID.
  always_comb begin
    wstate_n  = wstate_r;
    awready_n = 1'b0;
    bvalid_n  = bvalid_r;
    bresp_n   = bresp_r;
    wr_en_s   = 1'b0;
    case (wstate_r)
      W_IDLE: begin
        if (awready_r && AWVALID && WVALID) begin
          wr_en_s  = 1'b1;
          wstate_n = W_RESP;
          bvalid_n = 1'b1;
          bresp_n  = reg_mapped(aw_off_s) ? RESP_OKAY : RESP_SLVERR;
        end else begin
          awready_n = AWVALID && WVALID && !bvalid_r;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          bvalid_n = 1'b0;
          wstate_n = W_IDLE;
        end else begin
          bvalid_n = 1'b1;
        end
      end
      default: wstate_n = W_IDLE;
    endcase
  end

  // CTRL update, flush strobe and next tready.
  always_comb begin
    if (wr_en_s && (aw_off_s == REG_CTRL) && WSTRB[0]) begin
      enable_n = WDATA[0];
      flush_s  = WDATA[1];
    end else begin
      enable_n = enable_r;
      flush_s  = 1'b0;
    end
`ifdef AXIS_RX_OVERFLOW_DROP_EN
    tready_n = enable_n;
`else
    tready_n = enable_n && (level_next_s != LW'(DEPTH));
`endif
  end

  // Read channel FSM: registered ARREADY pulse, then hold RVALID/RDATA.
  always_comb begin
    rstate_n  = rstate_r;
    arready_n = 1'b0;
    rvalid_n  = rvalid_r;
    rdata_n   = rdata_r;
    rresp_n   = rresp_r;
    rd_en_s   = 1'b0;
    case (rstate_r)
      R_IDLE: begin
        if (arready_r && ARVALID) begin
          rd_en_s  = 1'b1;
          rstate_n = R_DATA;
          rvalid_n = 1'b1;
          rdata_n  = rd_mux_s;
          rresp_n  = rd_resp_s;
        end else begin
          arready_n = ARVALID && !rvalid_r;
        end
      end
      R_DATA: begin
        if (RREADY) begin
          rvalid_n = 1'b0;
          rstate_n = R_IDLE;
        end else begin
          rvalid_n = 1'b1;
        end
      end
      default: rstate_n = R_IDLE;
    endcase
  end

  // Read data mux.
  always_comb begin
    status_s = 32'd0;
    status_s[STAT_EMPTY] = empty_s;
    status_s[STAT_FULL]  = full_s;
    status_s[STAT_TLAST] = head_s.tlast;
    status_s[STAT_KEEP_LSB +: 8]   = head_s.tkeep;
    status_s[STAT_LEVEL_LSB +: 16] = 16'(level_s);
    rd_resp_s = RESP_OKAY;
    case (ar_off_s)
      REG_STATUS:    rd_mux_s = status_s;
      REG_DATA_LO:   rd_mux_s = head_s.tdata[31:0];
      REG_DATA_HI:   rd_mux_s = head_s.tdata[63:32];
      REG_CTRL:      rd_mux_s = {31'd0, enable_r};
      REG_FRAME_CNT: rd_mux_s = frame_cnt_r;
      REG_DROP_CNT:  rd_mux_s = drop_cnt_s;
      default: begin
        rd_mux_s  = 32'd0;
        rd_resp_s = RESP_SLVERR;
      end
    endcase
  end

  // Handshake, control and frame counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_r    <= W_IDLE;
      rstate_r    <= R_IDLE;
      awready_r   <= 1'b0;
      bvalid_r    <= 1'b0;
      bresp_r     <= 2'b00;
      arready_r   <= 1'b0;
      rvalid_r    <= 1'b0;
      rdata_r     <= 32'd0;
      rresp_r     <= 2'b00;
      enable_r    <= 1'b0;
      tready_r    <= 1'b0;
      frame_cnt_r <= 32'd0;
    end else begin
      wstate_r    <= wstate_n;
      rstate_r    <= rstate_n;
      awready_r   <= awready_n;
      bvalid_r    <= bvalid_n;
      bresp_r     <= bresp_n;
      arready_r   <= arready_n;
      rvalid_r    <= rvalid_n;
      rdata_r     <= rdata_n;
      rresp_r     <= rresp_n;
      enable_r    <= enable_n;
      tready_r    <= tready_n;
      frame_cnt_r <= (push_ok_s && tlast) ? frame_cnt_r + 32'd1 : frame_cnt_r;
    end
  end

`ifdef AXIS_RX_OVERFLOW_DROP_EN
  logic [31:0] drop_cnt_r;

  // Saturating count of beats discarded on overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_r <= 32'd0;
    end else if (tvalid && tready_r && full_s && !flush_s && (drop_cnt_r != 32'hFFFF_FFFF)) begin
      drop_cnt_r <= drop_cnt_r + 32'd1;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign drop_cnt_s = drop_cnt_r;
`else
  assign drop_cnt_s = 32'd0;
`endif

  assign AWREADY = awready_r;
  assign WREADY  = awready_r;
  assign BVALID  = bvalid_r;
  assign BRESP   = bresp_r;
  assign ARREADY = arready_r;
  assign RVALID  = rvalid_r;
  assign RDATA   = rdata_r;
  assign RRESP   = rresp_r;
  assign tready  = tready_r;

endmodule

// File: tb/tb_axis_rx_mailbox.sv
// Directed bench for axis_rx_mailbox: AXI4-Lite master tasks, an AXI-Stream
// source, a queue model of the FIFO and a scoreboard of expected read data.
module tb_axis_rx_mailbox;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] AWADDR, WDATA, ARADDR;
  logic [2:0]  AWPROT, ARPROT;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic [3:0]  WSTRB;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast, tvalid, tready;

  int vectors = 0;
  int miscompares = 0;
  logic [72:0] mdl[$];
  logic [33:0] rd_q[$];
  logic [1:0]  b_q[$];
  logic [31:0] frame_exp = 32'd0;
  logic [31:0] drop_exp = 32'd0;

  axis_rx_mailbox #(.DEPTH(DEPTH), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .tdata(tdata), .tkeep(tkeep), .tlast(tlast), .tvalid(tvalid), .tready(tready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_exp();
    logic [31:0] s;
    s = 32'd0;
    s[0] = (mdl.size() == 0);
    s[1] = (mdl.size() == DEPTH);
    if (mdl.size() > 0) begin
      s[2]    = mdl[0][72];
      s[15:8] = mdl[0][71:64];
    end
    s[31:16] = 16'(mdl.size());
    return s;
  endfunction

  task automatic axil_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp);
    int n;
    b_q.push_back(exp_resp);
    @(negedge clk);
    AWADDR = addr; WDATA = data; WSTRB = strb; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    n = 0;
    while (!AWREADY && n < 20) begin @(negedge clk); n++; end
    check({tag, "_awready"}, AWREADY, 1);
    check({tag, "_wready"}, WREADY, 1);
    @(posedge clk); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    n = 0;
    while (!BVALID && n < 20) begin @(negedge clk); n++; end
    check({tag, "_bvalid"}, BVALID, 1);
    check({tag, "_bresp"}, BRESP, b_q.pop_front());
    BREADY = 1'b1;
    @(posedge clk); #1;
    BREADY = 1'b0;
  endtask

  task automatic axil_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input int hold);
    int n;
    logic [33:0] e;
    rd_q.push_back({exp_resp, exp_data});
    @(negedge clk);
    ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b0;
    n = 0;
    while (!ARREADY && n < 20) begin @(negedge clk); n++; end
    check({tag, "_arready"}, ARREADY, 1);
    @(posedge clk); #1;
    ARVALID = 1'b0;
    n = 0;
    while (!RVALID && n < 20) begin @(negedge clk); n++; end
    check({tag, "_rvalid"}, RVALID, 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_rvalid"}, RVALID, 1);
      check({tag, "_hold_rdata"}, RDATA, exp_data);
    end
    e = rd_q.pop_front();
    check({tag, "_rdata"}, RDATA, e[31:0]);
    check({tag, "_rresp"}, RRESP, e[33:32]);
    RREADY = 1'b1;
    @(posedge clk); #1;
    RREADY = 1'b0;
    if (addr[7:2] == 6'd2 && mdl.size() > 0) void'(mdl.pop_front());
  endtask

  task automatic stream_send(input logic [63:0] d, input logic [7:0] k, input logic l);
    int n;
    @(negedge clk);
    tdata = d; tkeep = k; tlast = l; tvalid = 1'b1;
    n = 0;
    while (!tready && n < 20) begin @(negedge clk); n++; end
    check("stream_tready", tready, 1);
    @(posedge clk); #1;
    tvalid = 1'b0;
    if (mdl.size() < DEPTH) begin
      mdl.push_back({l, k, d});
      if (l) frame_exp++;
    end else begin
      drop_exp++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    AWADDR = 32'd0; WDATA = 32'd0; ARADDR = 32'd0; AWPROT = 3'd0; ARPROT = 3'd0;
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;
    WSTRB = 4'd0; tdata = 64'd0; tkeep = 8'd0; tlast = 1'b0; tvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tready", tready, 0);
    check("rst_awready", AWREADY, 0);
    check("rst_wready", WREADY, 0);
    check("rst_bvalid", BVALID, 0);
    check("rst_arready", ARREADY, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_rdata", RDATA, 0);
    check("rst_resps", {BRESP, RRESP}, 0);
    rst_n = 1'b1;

    axil_read("status_rst", 32'h00, 32'h0000_0001, 2'b00, 0);
    check("tready_disabled", tready, 0);
    axil_write("enable", 32'h0C, 32'h1, 4'hF, 2'b00);
    @(negedge clk);
    check("tready_enabled", tready, 1);

    stream_send(64'h1122_3344_5566_7788, 8'hFF, 1'b0);
    stream_send(64'hAABB_CCDD_0000_0001, 8'h0F, 1'b1);
    axil_read("status_two", 32'h00, 32'h0002_FF00, 2'b00, 0);
    axil_read("data_lo", 32'h04, 32'h5566_7788, 2'b00, 0);
    axil_read("data_hi_pop", 32'h08, 32'h1122_3344, 2'b00, 0);
    axil_read("status_one", 32'h00, 32'h0001_0F04, 2'b00, 0);
    axil_read("frame_cnt1", 32'h10, 32'd1, 2'b00, 0);
    axil_read("drain", 32'h08, 32'hAABB_CCDD, 2'b00, 0);

    for (int i = 0; i < DEPTH; i++)
      stream_send({32'hC0DE_0000 | 32'(i), 32'h1000_0000 + 32'(i)}, 8'hF0 ^ 8'(i), (i % 4) == 3);
    @(negedge clk);
`ifdef AXIS_RX_OVERFLOW_DROP_EN
    check("full_tready", tready, 1);
    for (int i = 0; i < 3; i++) stream_send({32'hDEAD_0000, 32'(i)}, 8'hFF, 1'b1);
    axil_read("drop_cnt", 32'h14, drop_exp, 2'b00, 0);
`else
    check("full_tready", tready, 0);
    axil_read("drop_cnt", 32'h14, 32'd0, 2'b00, 0);
`endif
    axil_read("status_full", 32'h00, status_exp(), 2'b00, 0);
    axil_read("frame_cnt_full", 32'h10, frame_exp, 2'b00, 0);
    axil_read("pop_full", 32'h08, mdl[0][63:32], 2'b00, 0);
    @(negedge clk);
    check("tready_after_pop", tready, 1);
    axil_read("head_lo", 32'h04, mdl[0][31:0], 2'b00, 0);
    stream_send(64'h0123_4567_89AB_CDEF, 8'h3C, 1'b1);
    axil_read("status_refill", 32'h00, status_exp(), 2'b00, 0);

    axil_write("flush", 32'h0C, 32'h3, 4'hF, 2'b00);
    mdl.delete();
    axil_read("status_flush", 32'h00, 32'h0000_0001, 2'b00, 0);
    axil_read("ctrl_after_flush", 32'h0C, 32'h1, 2'b00, 0);
    axil_read("data_hi_empty", 32'h08, 32'd0, 2'b00, 0);
    axil_read("frame_cnt_kept", 32'h10, frame_exp, 2'b00, 0);
    check("tready_after_flush", tready, 1);

    axil_read("unmapped_rd", 32'h20, 32'd0, 2'b10, 5);
    axil_write("unmapped_wr", 32'h20, 32'hFFFF_FFFF, 4'hF, 2'b10);
    axil_write("ro_write", 32'h00, 32'hFFFF_FFFF, 4'hF, 2'b00);
    axil_read("status_after_ro", 32'h00, 32'h0000_0001, 2'b00, 0);
    axil_write("ctrl_nostrb", 32'h0C, 32'h0, 4'h0, 2'b00);
    axil_read("ctrl_kept", 32'h0C, 32'h1, 2'b00, 0);
    axil_read("alias_status", 32'h100, 32'h0000_0001, 2'b00, 0);
    axil_write("disable", 32'h0C, 32'h0, 4'h1, 2'b00);
    axil_read("ctrl_off", 32'h0C, 32'h0, 2'b00, 0);
    check("tready_off", tready, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
